// File: rtl/mmss_counter.sv
// -----------------------------------------------------------------------------
// mmss_counter
//
// Minutes:seconds BCD counter (00:00 .. 59:59) advanced by an internal 1 Hz
// prescaler derived from the system clock. The four BCD digits go straight to
// the display/scan logic.
//
// Parameters
//   CLK_FREQ   input clock frequency in Hz (>= 2); one tick per CLK_FREQ cycles
//
// Ports
//   clk        system clock, all logic on the rising edge
//   res        synchronous active-low reset
//   run        1 = prescaler advances, 0 = prescaler and digits hold
//   up_dn      1 = count up, 0 = count down (holds at 00:00)
//   load       one-cycle strobe, loads ld_* digits when all are in range
//   ld_min_t   minutes tens to load (0..5)
//   ld_min_u   minutes units to load (0..9)
//   ld_sec_t   seconds tens to load (0..5)
//   ld_sec_u   seconds units to load (0..9)
//   min_t, min_u, sec_t, sec_u   registered BCD digits
//   tick       registered one-cycle 1 Hz pulse
//   wrap       registered pulse in the cycle 00:00 first appears after 59:59
//   zero       level, all four digits are 0
//   ld_err     registered pulse when a load is rejected
// -----------------------------------------------------------------------------
module mmss_counter #(
  parameter int CLK_FREQ = 24000000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       run,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] ld_min_t,
  input  logic [3:0] ld_min_u,
  input  logic [3:0] ld_sec_t,
  input  logic [3:0] ld_sec_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       tick,
  output logic       wrap,
  output logic       zero,
  output logic       ld_err
);

  // Prescaler width, never narrower than one bit.
  localparam int DIV_W = ($clog2(CLK_FREQ) < 1) ? 1 : $clog2(CLK_FREQ);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_tick;
  logic             r_wrap;
  logic             r_ld_err;
  logic [3:0]       r_min_t;
  logic [3:0]       r_min_u;
  logic [3:0]       r_sec_t;
  logic [3:0]       r_sec_u;

  logic             w_ld_ok;
  logic             w_ld_take;
  logic             w_ld_bad;
  logic             w_at_max;
  logic             w_at_zero;
  logic [3:0]       w_nxt_min_t;
  logic [3:0]       w_nxt_min_u;
  logic [3:0]       w_nxt_sec_t;
  logic [3:0]       w_nxt_sec_u;

  // A load is only accepted when every digit is a legal BCD value for its
  // position; otherwise the whole load is dropped and flagged.
  assign w_ld_ok   = (ld_min_t <= 4'd5) && (ld_min_u <= 4'd9) &&
                     (ld_sec_t <= 4'd5) && (ld_sec_u <= 4'd9);
  assign w_ld_take = load & w_ld_ok;
  assign w_ld_bad  = load & ~w_ld_ok;

  assign w_at_max  = (r_min_t == 4'd5) && (r_min_u == 4'd9) &&
                     (r_sec_t == 4'd5) && (r_sec_u == 4'd9);
  assign w_at_zero = (r_min_t == 4'd0) && (r_min_u == 4'd0) &&
                     (r_sec_t == 4'd0) && (r_sec_u == 4'd0);

  // Next digit values for a one-second step in the current direction.
  always_comb begin
    w_nxt_min_t = r_min_t;
    w_nxt_min_u = r_min_u;
    w_nxt_sec_t = r_sec_t;
    w_nxt_sec_u = r_sec_u;
    if (up_dn) begin
      // Carry cascade; 59:59 naturally rolls over to 00:00.
      if (r_sec_u == 4'd9) begin
        w_nxt_sec_u = 4'd0;
        if (r_sec_t == 4'd5) begin
          w_nxt_sec_t = 4'd0;
          if (r_min_u == 4'd9) begin
            w_nxt_min_u = 4'd0;
            if (r_min_t == 4'd5) begin
              w_nxt_min_t = 4'd0;
            end else begin
              w_nxt_min_t = r_min_t + 4'd1;
            end
          end else begin
            w_nxt_min_u = r_min_u + 4'd1;
          end
        end else begin
          w_nxt_sec_t = r_sec_t + 4'd1;
        end
      end else begin
        w_nxt_sec_u = r_sec_u + 4'd1;
      end
    end else if (w_at_zero) begin
      // Countdown stops at 00:00 instead of wrapping to 59:59.
      w_nxt_min_t = 4'd0;
      w_nxt_min_u = 4'd0;
      w_nxt_sec_t = 4'd0;
      w_nxt_sec_u = 4'd0;
    end else begin
      // Borrow cascade; units reload to 9, tens reload to 5.
      if (r_sec_u == 4'd0) begin
        w_nxt_sec_u = 4'd9;
        if (r_sec_t == 4'd0) begin
          w_nxt_sec_t = 4'd5;
          if (r_min_u == 4'd0) begin
            w_nxt_min_u = 4'd9;
            if (r_min_t == 4'd0) begin
              w_nxt_min_t = 4'd5;
            end else begin
              w_nxt_min_t = r_min_t - 4'd1;
            end
          end else begin
            w_nxt_min_u = r_min_u - 4'd1;
          end
        end else begin
          w_nxt_sec_t = r_sec_t - 4'd1;
        end
      end else begin
        w_nxt_sec_u = r_sec_u - 4'd1;
      end
    end
  end

  // Prescaler: counts while running and emits a one-cycle tick on terminal
  // count. An accepted load restarts the second so a full period follows it.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (w_ld_take) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (run) begin
      if (r_div_cnt == DIV_LAST) begin
        r_div_cnt <= '0;
        r_tick    <= 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
        r_tick    <= 1'b0;
      end
    end else begin
      r_div_cnt <= r_div_cnt;
      r_tick    <= 1'b0;
    end
  end

  // Digit registers: load beats the tick-driven step. The step keys off the
  // registered tick, so dropping run while tick is high still takes effect.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_min_t <= 4'd0;
      r_min_u <= 4'd0;
      r_sec_t <= 4'd0;
      r_sec_u <= 4'd0;
    end else if (w_ld_take) begin
      r_min_t <= ld_min_t;
      r_min_u <= ld_min_u;
      r_sec_t <= ld_sec_t;
      r_sec_u <= ld_sec_u;
    end else if (r_tick) begin
      r_min_t <= w_nxt_min_t;
      r_min_u <= w_nxt_min_u;
      r_sec_t <= w_nxt_sec_t;
      r_sec_u <= w_nxt_sec_u;
    end else begin
      r_min_t <= r_min_t;
      r_min_u <= r_min_u;
      r_sec_t <= r_sec_t;
      r_sec_u <= r_sec_u;
    end
  end

  // Status pulses: wrap lines up with the cycle 00:00 is first shown,
  // ld_err with the cycle after the rejected load.
  always_ff @(posedge clk) begin
    if (!res) begin
      r_wrap   <= 1'b0;
      r_ld_err <= 1'b0;
    end else if (w_ld_take) begin
      r_wrap   <= 1'b0;
      r_ld_err <= 1'b0;
    end else begin
      r_wrap   <= r_tick & up_dn & w_at_max;
      r_ld_err <= w_ld_bad;
    end
  end

  assign min_t  = r_min_t;
  assign min_u  = r_min_u;
  assign sec_t  = r_sec_t;
  assign sec_u  = r_sec_u;
  assign tick   = r_tick;
  assign wrap   = r_wrap;
  assign ld_err = r_ld_err;
  assign zero   = w_at_zero;

endmodule

// File: tb/tb_mmss_counter.sv
// -----------------------------------------------------------------------------
// tb_mmss_counter
//
// Directed bench for mmss_counter with CLK_FREQ=4. Inputs change 1 time unit
// after a rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_mmss_counter;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       run = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] ld_min_t = 4'd0;
  logic [3:0] ld_min_u = 4'd0;
  logic [3:0] ld_sec_t = 4'd0;
  logic [3:0] ld_sec_u = 4'd0;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic       tick, wrap, zero, ld_err;

  int checks = 0;
  int failures = 0;

  mmss_counter #(.CLK_FREQ(4)) dut (
    .clk(clk), .res(res), .run(run), .up_dn(up_dn), .load(load),
    .ld_min_t(ld_min_t), .ld_min_u(ld_min_u),
    .ld_sec_t(ld_sec_t), .ld_sec_u(ld_sec_u),
    .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
    .tick(tick), .wrap(wrap), .zero(zero), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {min_t, min_u, sec_t, sec_u};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until tick is seen; n is the number of edges taken (20 = timeout).
  task automatic wait_tick(output int n);
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic set_ld(input logic [15:0] v);
    {ld_min_t, ld_min_u, ld_sec_t, ld_sec_u} = v;
  endtask

  task automatic do_load(input logic [15:0] v);
    set_ld(v);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b0; run = 1'b1; load = 1'b1; set_ld(16'h1234);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (digits() !== 16'h0000) begin
        failures++; $display("FAIL reset_digits got=%h exp=0000", digits());
      end
      checks++;
      if (zero !== 1'b1) begin
        failures++; $display("FAIL reset_zero got=%b exp=1", zero);
      end
      checks++;
      if ({tick, wrap, ld_err} !== 3'b000) begin
        failures++; $display("FAIL reset_pulses got=%b exp=000", {tick, wrap, ld_err});
      end
    end
    load = 1'b0;
    res = 1'b1;
  endtask

  task automatic test_up_count();
    int n;
    logic [15:0] exp;
    up_dn = 1'b1;
    wait_tick(n);
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL first_tick edges=%0d exp=4", n);
    end
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin
        wait_tick(n);
        checks++;
        if (n !== 3) begin
          failures++; $display("FAIL up_spacing k=%0d edges=%0d exp=3", k, n);
        end
      end
      step();
      exp = (k == 10) ? 16'h0010 : 16'(k);
      checks++;
      if (digits() !== exp) begin
        failures++; $display("FAIL up_digits k=%0d got=%h exp=%h", k, digits(), exp);
      end
      checks++;
      if (tick !== 1'b0) begin
        failures++; $display("FAIL up_tick_width k=%0d got=%b exp=0", k, tick);
      end
      if (k == 1) begin
        checks++;
        if (zero !== 1'b0) begin
          failures++; $display("FAIL up_zero_fall got=%b exp=0", zero);
        end
      end
    end
  endtask

  task automatic test_rollover();
    int n;
    do_load(16'h5958);
    checks++;
    if (digits() !== 16'h5958 || tick !== 1'b0) begin
      failures++; $display("FAIL roll_load got=%h tick=%b exp=5958 tick=0", digits(), tick);
    end
    wait_tick(n);
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL roll_after_load edges=%0d exp=4", n);
    end
    step();
    checks++;
    if (digits() !== 16'h5959 || wrap !== 1'b0) begin
      failures++; $display("FAIL roll_5959 got=%h wrap=%b exp=5959 wrap=0", digits(), wrap);
    end
    wait_tick(n);
    step();
    checks++;
    if (digits() !== 16'h0000 || wrap !== 1'b1 || zero !== 1'b1) begin
      failures++; $display("FAIL roll_wrap got=%h wrap=%b zero=%b exp=0000 1 1", digits(), wrap, zero);
    end
    step();
    checks++;
    if (wrap !== 1'b0 || digits() !== 16'h0000) begin
      failures++; $display("FAIL roll_wrap_width got=%h wrap=%b exp=0000 wrap=0", digits(), wrap);
    end
  endtask

  task automatic test_countdown();
    int n;
    up_dn = 1'b0;
    do_load(16'h0100);
    wait_tick(n);
    step();
    checks++;
    if (digits() !== 16'h0059) begin
      failures++; $display("FAIL down_borrow got=%h exp=0059", digits());
    end
    do_load(16'h0001);
    wait_tick(n);
    step();
    checks++;
    if (digits() !== 16'h0000 || zero !== 1'b1) begin
      failures++; $display("FAIL down_zero got=%h zero=%b exp=0000 1", digits(), zero);
    end
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      checks++;
      if (n !== 3) begin
        failures++; $display("FAIL down_hold_tick i=%0d edges=%0d exp=3", i, n);
      end
      step();
      checks++;
      if (digits() !== 16'h0000 || wrap !== 1'b0) begin
        failures++; $display("FAIL down_hold i=%0d got=%h wrap=%b exp=0000 0", i, digits(), wrap);
      end
    end
  endtask

  task automatic test_bad_load();
    int n;
    up_dn = 1'b1;
    do_load(16'h1234);
    checks++;
    if (digits() !== 16'h1234) begin
      failures++; $display("FAIL bad_setup got=%h exp=1234", digits());
    end
    step();
    set_ld(16'h1264);
    load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (ld_err !== 1'b1 || digits() !== 16'h1234) begin
      failures++; $display("FAIL bad_reject got=%h ld_err=%b exp=1234 1", digits(), ld_err);
    end
    step();
    checks++;
    if (ld_err !== 1'b0) begin
      failures++; $display("FAIL bad_err_width got=%b exp=0", ld_err);
    end
    wait_tick(n);
    checks++;
    if (n !== 1) begin
      failures++; $display("FAIL bad_spacing edges=%0d exp=1", n);
    end
    step();
    checks++;
    if (digits() !== 16'h1235) begin
      failures++; $display("FAIL bad_next got=%h exp=1235", digits());
    end
  endtask

  task automatic test_pause();
    int n;
    logic seen;
    seen = 1'b0;
    step();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || digits() !== 16'h1235) begin
      failures++; $display("FAIL pause_hold tick_seen=%b got=%h exp=0 1235", seen, digits());
    end
    run = 1'b1;
    wait_tick(n);
    checks++;
    if (n !== 2) begin
      failures++; $display("FAIL pause_resume edges=%0d exp=2", n);
    end
    step();
    checks++;
    if (digits() !== 16'h1236) begin
      failures++; $display("FAIL pause_next got=%h exp=1236", digits());
    end
  endtask

  task automatic test_run_fall();
    int n;
    wait_tick(n);
    checks++;
    if (n !== 3) begin
      failures++; $display("FAIL runfall_tick edges=%0d exp=3", n);
    end
    run = 1'b0;
    step();
    checks++;
    if (digits() !== 16'h1237 || tick !== 1'b0) begin
      failures++; $display("FAIL runfall_update got=%h tick=%b exp=1237 0", digits(), tick);
    end
    run = 1'b1;
  endtask

  task automatic test_load_tick();
    int n;
    wait_tick(n);
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL ldtick_wait edges=%0d exp=4", n);
    end
    do_load(16'h0321);
    checks++;
    if (digits() !== 16'h0321) begin
      failures++; $display("FAIL ldtick_load got=%h exp=0321", digits());
    end
    step();
    checks++;
    if (digits() !== 16'h0321 || tick !== 1'b0) begin
      failures++; $display("FAIL ldtick_no_inc got=%h tick=%b exp=0321 0", digits(), tick);
    end
    wait_tick(n);
    checks++;
    if (n !== 3) begin
      failures++; $display("FAIL ldtick_spacing edges=%0d exp=3", n);
    end
    step();
    checks++;
    if (digits() !== 16'h0322) begin
      failures++; $display("FAIL ldtick_next got=%h exp=0322", digits());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    step();
    step();
    res = 1'b0;
    step();
    checks++;
    if (digits() !== 16'h0000 || zero !== 1'b1 || tick !== 1'b0) begin
      failures++; $display("FAIL midreset got=%h zero=%b tick=%b exp=0000 1 0", digits(), zero, tick);
    end
    res = 1'b1;
    wait_tick(n);
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL midreset_period edges=%0d exp=4", n);
    end
    step();
    checks++;
    if (digits() !== 16'h0001) begin
      failures++; $display("FAIL midreset_count got=%h exp=0001", digits());
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_rollover();
    test_countdown();
    test_bad_load();
    test_pause();
    test_run_fall();
    test_load_tick();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
